// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: latches a resolved taken branch/jump target, runs the
// PC-select handshake with IF, then flushes the wrong-path fetches. Optional BRANCH_PERF_EN
// adds saturating resolved/taken counters.
module branch_redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branch_valid,
  input  logic                 branchN,
  input  logic                 jump,
  input  logic                 ex_stall,
  input  logic [31:0]          target,
  input  logic                 ifetch_ready,
  output logic                 pc_redirect,
  output logic [31:0]          redirect_pc,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 busy,
  output logic                 misalign,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] taken_cnt
);

  localparam int unsigned FC_W = 3;
  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [FC_W-1:0] cnt_q;
  logic [FC_W-1:0] cnt_d;

  logic            pc_redirect_d;
  logic [PC_W-1:0] redirect_pc_d;
  logic            flush_if_id_d;
  logic            flush_id_ex_d;
  logic            busy_d;
  logic            misalign_d;

  logic accept_c;
  logic taken_c;
  logic aligned_c;
  logic redirect_go_c;
  logic handshake_c;
  logic flush_last_c;

  // Resolution is only sampled in IDLE; anything seen while busy is wrong-path.
  assign accept_c      = (state_q == IDLE) && branch_valid && !ex_stall;
  assign taken_c       = accept_c && (branchN || jump);
  assign aligned_c     = (target[1:0] == 2'b00);
  assign redirect_go_c = taken_c && aligned_c;
  assign handshake_c   = (state_q == REDIRECT) && pc_redirect && ifetch_ready;
  assign flush_last_c  = (cnt_q <= FC_W'(1));

  // State, flush counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
      busy        <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_redirect <= pc_redirect_d;
      redirect_pc <= redirect_pc_d;
      flush_if_id <= flush_if_id_d;
      flush_id_ex <= flush_id_ex_d;
      busy        <= busy_d;
      misalign    <= misalign_d;
    end
  end

  // Next-state and flush-counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (redirect_go_c) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (handshake_c) begin
          state_d = FLUSH;
          cnt_d   = FC_W'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (flush_last_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output values for the cycle after this one.
  always_comb begin
    pc_redirect_d = 1'b0;
    redirect_pc_d = redirect_pc;
    flush_if_id_d = 1'b0;
    flush_id_ex_d = 1'b0;
    busy_d        = 1'b0;
    misalign_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_go_c) begin
          pc_redirect_d = 1'b1;
          redirect_pc_d = target;
          flush_if_id_d = 1'b1;
          flush_id_ex_d = 1'b1;
          busy_d        = 1'b1;
        end else if (taken_c) begin
          misalign_d = 1'b1;
        end
      end
      REDIRECT: begin
        // ID/EX squash is a single pulse on entry; IF/ID squash covers the whole wait.
        pc_redirect_d = !handshake_c;
        flush_if_id_d = 1'b1;
        busy_d        = 1'b1;
      end
      FLUSH: begin
        if (!flush_last_c) begin
          flush_if_id_d = 1'b1;
          busy_d        = 1'b1;
        end
      end
      default: begin
        pc_redirect_d = 1'b0;
      end
    endcase
  end

`ifdef BRANCH_PERF_EN
  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (accept_c && !(&branch_cnt)) begin
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      end
      if (redirect_go_c && !(&taken_cnt)) begin
        taken_cnt <= taken_cnt + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign branch_cnt = '0;
  assign taken_cnt  = '0;
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the front-end redirect after the EX-stage branch comparator resolves a taken branch or jump.
- Latches the target and drives the PC-select/redirect handshake with instruction fetch.
- Issues pipeline flushes and holds off further resolution until the wrong-path fetches have drained.
- Sits between the EX-stage branch comparator (branchN), the PC register/IF stage and the pipeline-register flush controls.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_if_id stays asserted after the redirect handshake; legal range 1..7.
- CNT_WIDTH, 16, width of the performance counters (only used with the optional feature).

Ports:
- clk  input  1  core clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- branch_valid  input  1  EX stage holds a valid branch/jump instruction this cycle.
- branchN  input  1  comparator result: conditional branch taken.
- jump  input  1  EX instruction is JAL/JALR (unconditionally taken).
- ex_stall  input  1  EX stage stalled this cycle (e.g. load-use); no resolution is accepted.
- target  input  32  computed branch/jump target address.
- ifetch_ready  input  1  IF accepts a redirect PC this cycle.
- pc_redirect  output  1  redirect request to the PC mux; held until ifetch_ready.
- redirect_pc  output  32  latched target, stable while pc_redirect=1.
- flush_if_id  output  1  squash the IF/ID register.
- flush_id_ex  output  1  squash the ID/EX register.
- busy  output  1  controller is not IDLE; new resolutions are ignored.
- misalign  output  1  one-cycle pulse: taken target has target[1:0]!=0.
- branch_cnt  output  CNT_WIDTH  resolved-branch count (optional feature).
- taken_cnt  output  CNT_WIDTH  redirect count (optional feature).

Behaviour:
- All outputs are registered.
- Reset, including mid-operation: state=IDLE, every output 0, redirect_pc=0, counters=0.
- Accept condition in cycle T: state=IDLE and branch_valid=1 and ex_stall=0.
- Taken condition: accepted and (branchN or jump).
- IDLE:
  - Not accepted, or accepted but not taken: stay IDLE, outputs 0.
  - Taken with target[1:0]!=0: at T+1 misalign=1 for one cycle; no redirect, no flush, stay IDLE.
  - Taken and aligned: at T+1 pc_redirect=1, redirect_pc=target, flush_if_id=1, flush_id_ex=1, busy=1, state=REDIRECT.
- REDIRECT:
  - pc_redirect, redirect_pc and busy held.
  - flush_id_ex is asserted only in the first REDIRECT cycle.
  - flush_if_id stays 1 throughout REDIRECT.
  - The handshake completes in the cycle where pc_redirect=1 and ifetch_ready=1.
  - If ifetch_ready=1 already in the first REDIRECT cycle, REDIRECT lasts exactly one cycle.
  - Next cycle: pc_redirect=0, state=FLUSH, counter loaded with FLUSH_CYCLES.
- FLUSH:
  - flush_if_id=1 and busy=1 for exactly FLUSH_CYCLES cycles; counter decrements each cycle.
  - Leaves to IDLE when the counter reaches 1.
  - The first IDLE cycle has busy=0 and may accept a new branch.
- While busy=1, branch_valid, branchN, jump, target and ex_stall are ignored; those instructions are wrong-path and already flushed.
- ex_stall=1 in IDLE blocks acceptance; the same branch is re-evaluated when the stall drops. ex_stall has no effect in REDIRECT or FLUSH.
- Total redirect penalty seen by IF: 1 + (REDIRECT cycles) + FLUSH_CYCLES.

Optional Feature:
- Macro BRANCH_PERF_EN.
- Defined:
  - branch_cnt increments on every accepted resolution.
  - taken_cnt increments on every aligned taken redirect (i.e. entry to REDIRECT).
  - Both counters saturate at all-ones and clear only on rst.
- Undefined: the ports still exist, are tied to 0, and no counter flops are inferred.

Test Plan:
- Reset mid-FLUSH: assert rst during a FLUSH cycle -> same cycle all outputs 0; after release, state IDLE; the next taken branch is accepted.
- Taken, ready immediate: branch_valid=1, branchN=1, target=0x0000_0100, ifetch_ready=1 -> T+1 pc_redirect=1, redirect_pc=0x100, both flushes=1; T+2..T+3 flush_if_id=1 only; T+4 busy=0.
- Redirect backpressure: jump=1, target=0x0000_2000, ifetch_ready=0 for 3 cycles -> pc_redirect and redirect_pc=0x2000 held 4 cycles; flush_id_ex=1 only in the first of them; then FLUSH for 2 cycles.
- Not taken plus stall: branch_valid=1, branchN=0 -> no outputs asserted, branch_cnt+1 (with BRANCH_PERF_EN). ex_stall=1 with a taken branch -> nothing until ex_stall=0, then redirect at the following cycle.
- Misaligned and ignored: taken with target=0x0000_0102 -> misalign pulse only, no flush. A taken branch presented while busy=1 -> ignored; taken_cnt increments once.
- Saturation: with CNT_WIDTH=4 and BRANCH_PERF_EN, 20 taken redirects -> taken_cnt=15, branch_cnt=15.
